ram_dp_sync: RTL and testbench
==============================

# ram_dp_sync

Parametrised synchronous dual-port RAM, the next-generation on-chip memory for the CPU datapath. Port A is read/write and port B is read-only. Both ports have registered outputs, a read-valid strobe and a selectable read-during-write collision policy. An optional post-reset clear sequencer zeroes every location before the block accepts requests.

## Interface
- DATA_WIDTH, 8: bits per word.
- ADDR_WIDTH, 10: address bits; DEPTH = 2**ADDR_WIDTH words.
- INIT_CLEAR, 1: 1 = zero all words after reset; 0 = no clear, contents undefined after power-up.
- RDW_MODE, 0: same-address collision (A write, B read, same edge): 0 = B returns old data, 1 = B returns new data.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- busy  out  1  high while the clear sequencer runs or rst is high; requests are ignored while high.
- a_en  in  1  port A request.
- a_we  in  1  port A write (qualified by a_en).
- a_addr  in  ADDR_WIDTH  port A address.
- a_din  in  DATA_WIDTH  port A write data.
- a_dout  out  DATA_WIDTH  port A registered read data.
- a_valid  out  1  one-cycle pulse: a_dout holds a port A read result.
- b_en  in  1  port B read request.
- b_addr  in  ADDR_WIDTH  port B address.
- b_dout  out  DATA_WIDTH  port B registered read data.
- b_valid  out  1  one-cycle pulse: b_dout holds a port B read result.

## Operation
- Reset values: a_dout=0, b_dout=0, a_valid=0, b_valid=0, busy=1, clear counter=0.
- Two-state FSM, CLEAR and READY.
  - Edge with rst=1 → CLEAR if INIT_CLEAR=1, else READY.
  - CLEAR: each edge writes 0 to mem[cnt] and increments cnt.
  - Edge with cnt=DEPTH-1 → READY and busy=0.
  - READY persists until rst.
  - busy=1 exactly while in CLEAR or during rst.
- Accepted request: en=1 in READY with rst=0. Non-accepted requests cause no write, no dout change and no valid pulse.
- Port A write (a_en=1, a_we=1):
  - mem[a_addr] <= a_din.
  - a_dout <= a_din if RDW_MODE=1, else the old mem[a_addr].
  - a_valid <= 0.
- Port A read (a_en=1, a_we=0): a_dout <= mem[a_addr], a_valid <= 1.
- Port B read (b_en=1): b_dout <= mem[b_addr], b_valid <= 1.
- Collision: an A write and a B read to the same address on the same edge resolve per RDW_MODE. The memory always ends up holding a_din.
- Both ports reading the same address: both return the stored value.
- Outputs hold their last value when the port is idle. Valid strobes deassert the cycle after any edge with no accepted read.
- Addresses are full ADDR_WIDTH decode with no aliasing. Address DEPTH-1 and address 0 are distinct words.

## Timing
- Read latency: 1 cycle. A request sampled at edge N gives dout/valid stable after edge N.
- Write latency: 1 cycle. Data is readable by either port from edge N+1 (same-edge reads follow RDW_MODE).
- Throughput: one access per port per cycle, with no stalls in READY.
- Clear duration, INIT_CLEAR=1: the first edge with rst=0 clears word 0; busy falls on edge DEPTH. The first accepted request is at edge DEPTH+1.
- Clear duration, INIT_CLEAR=0: busy falls on the first edge with rst=0.
- rst mid-clear or mid-traffic:
  - All outputs return to their reset values on the next edge.
  - cnt restarts at 0 and the clear reruns in full.
  - An in-flight read produces no valid pulse.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4, INIT_CLEAR=1 unless stated.
- Reset 2 cycles then release → busy high for exactly 16 edges. A read of addr 5 then gives b_dout=0x00 with b_valid one cycle later.
- A writes 0x05@0 and 0x15@1, then A reads 0 and B reads 1 on the same edge → a_dout=0x05 and b_dout=0x15, both valids pulse for 1 cycle.
- mem[3]=0xAA; A writes 0x55@3 while B reads 3:
  - RDW_MODE=0 → b_dout=0xAA.
  - RDW_MODE=1 → b_dout=0x55.
  - A following B read of 3 → 0x55.
- A write of 0x77@2 during busy is ignored → a_valid stays 0; after busy falls, a read of 2 returns 0x00.
- Write 0x33@7, assert rst 1 cycle, then assert rst again 5 edges into the clear:
  - Outputs go to 0.
  - busy stays high 16 edges after the final release.
  - A read of 7 returns 0x00.
- Write 0xF0@15 and 0x0F@0, read both on separate ports → 0xF0 and 0x0F (no wrap alias). Back-to-back reads of 0..15 give 16 consecutive valid pulses.

Source files
------------

// File: rtl/ram_dp_sync_if.sv
// Request/response bundle for ram_dp_sync: port A read/write, port B read-only, plus busy.
interface ram_dp_sync_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 10
);
   logic                  busy;
   logic                  a_en;
   logic                  a_we;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [DATA_WIDTH-1:0] a_din;
   logic [DATA_WIDTH-1:0] a_dout;
   logic                  a_valid;
   logic                  b_en;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [DATA_WIDTH-1:0] b_dout;
   logic                  b_valid;

   modport master (
      output a_en, a_we, a_addr, a_din, b_en, b_addr,
      input  busy, a_dout, a_valid, b_dout, b_valid
   );

   modport slave (
      input  a_en, a_we, a_addr, a_din, b_en, b_addr,
      output busy, a_dout, a_valid, b_dout, b_valid
   );
endinterface

// File: rtl/ram_dp_sync.sv
// Synchronous dual-port RAM: port A read/write, port B read-only, registered outputs,
// selectable read-during-write policy and an optional post-reset zeroing sequencer.
module ram_dp_sync #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter bit          INIT_CLEAR = 1'b1,
   parameter bit          RDW_MODE   = 1'b0
) (
   input logic         clk,
   input logic         rst,
   ram_dp_sync_if.slave bus
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  busy_q;
   logic [DATA_WIDTH-1:0] a_dout_q;
   logic [DATA_WIDTH-1:0] b_dout_q;
   logic                  a_valid_q;
   logic                  b_valid_q;

   logic                  accept;
   logic                  a_wr;
   logic                  a_rd;
   logic                  b_rd;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // Request qualification and the single write path shared by clear and port A
   always_comb begin
      accept    = (state == S_READY) && !busy_q && !rst;
      a_wr      = accept && bus.a_en && bus.a_we;
      a_rd      = accept && bus.a_en && !bus.a_we;
      b_rd      = accept && bus.b_en;
      mem_we    = 1'b0;
      mem_waddr = bus.a_addr;
      mem_wdata = bus.a_din;
      if ((state == S_CLEAR) && !rst) begin
         mem_we    = 1'b1;
         mem_waddr = cnt;
         mem_wdata = '0;
      end else if (a_wr) begin
         mem_we = 1'b1;
      end
   end

   // Storage array kept reset-free so it maps onto a memory macro
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT_CLEAR ? S_CLEAR : S_READY;
         cnt       <= '0;
         busy_q    <= 1'b1;
         a_dout_q  <= '0;
         b_dout_q  <= '0;
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
      end else begin
         a_valid_q <= a_rd;
         b_valid_q <= b_rd;
         case (state)
            S_CLEAR: begin
               cnt <= cnt + ADDR_WIDTH'(1);
               if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                  state  <= S_READY;
                  busy_q <= 1'b0;
               end
            end
            default: busy_q <= 1'b0;
         endcase
         // Read-during-write on A returns either the pre-write word or the new data
         if (a_wr) begin
            a_dout_q <= RDW_MODE ? bus.a_din : mem[bus.a_addr];
         end else if (a_rd) begin
            a_dout_q <= mem[bus.a_addr];
         end
         if (b_rd) begin
            b_dout_q <= (RDW_MODE && a_wr && (bus.a_addr == bus.b_addr)) ? bus.a_din
                                                                         : mem[bus.b_addr];
         end
      end
   end

   assign bus.busy    = busy_q;
   assign bus.a_dout  = a_dout_q;
   assign bus.b_dout  = b_dout_q;
   assign bus.a_valid = a_valid_q;
   assign bus.b_valid = b_valid_q;
endmodule

// File: tb/tb_ram_dp_sync.sv
// Bench for ram_dp_sync: two instances (old-data and new-data collision policy) share
// one stimulus stream and are compared against an array-based reference model.
module tb_ram_dp_sync;
   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ram_dp_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
   ram_dp_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

   ram_dp_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_CLEAR(1'b1), .RDW_MODE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave));
   ram_dp_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_CLEAR(1'b1), .RDW_MODE(1'b1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave));

   int checks = 0;
   int errors = 0;

   // Reference model: memory image, remaining clear edges, expected outputs per policy
   logic [DW-1:0] m_mem [DEPTH];
   int            m_clear_left = 0;
   logic          m_busy;
   logic          m_avalid;
   logic          m_bvalid;
   logic [DW-1:0] m_adout [2];
   logic [DW-1:0] m_bdout [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic ae, input logic aw,
                             input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                             input logic be, input logic [AW-1:0] ba);
      logic [DW-1:0] old_a;
      logic [DW-1:0] old_b;
      if (r) begin
         m_clear_left = DEPTH;
         m_busy       = 1'b1;
         m_avalid     = 1'b0;
         m_bvalid     = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_adout[k] = '0;
            m_bdout[k] = '0;
         end
      end else if (m_clear_left > 0) begin
         m_mem[DEPTH - m_clear_left] = '0;
         m_clear_left--;
         m_busy   = (m_clear_left > 0);
         m_avalid = 1'b0;
         m_bvalid = 1'b0;
      end else begin
         old_a    = m_mem[aa];
         old_b    = m_mem[ba];
         m_avalid = 1'b0;
         m_bvalid = 1'b0;
         if (ae && aw) begin
            m_adout[0] = old_a;
            m_adout[1] = ad;
            m_mem[aa]  = ad;
         end else if (ae) begin
            m_adout[0] = old_a;
            m_adout[1] = old_a;
            m_avalid   = 1'b1;
         end
         if (be) begin
            m_bdout[0] = old_b;
            m_bdout[1] = (ae && aw && (aa == ba)) ? ad : old_b;
            m_bvalid   = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      check("busy0",    32'(bus0.busy),    32'(m_busy));
      check("busy1",    32'(bus1.busy),    32'(m_busy));
      check("a_valid0", 32'(bus0.a_valid), 32'(m_avalid));
      check("a_valid1", 32'(bus1.a_valid), 32'(m_avalid));
      check("b_valid0", 32'(bus0.b_valid), 32'(m_bvalid));
      check("b_valid1", 32'(bus1.b_valid), 32'(m_bvalid));
      check("a_dout0",  32'(bus0.a_dout),  32'(m_adout[0]));
      check("a_dout1",  32'(bus1.a_dout),  32'(m_adout[1]));
      check("b_dout0",  32'(bus0.b_dout),  32'(m_bdout[0]));
      check("b_dout1",  32'(bus1.b_dout),  32'(m_bdout[1]));
   endtask

   // One clock: drive both instances, step the model, compare everything
   task automatic cyc(input logic r, input logic ae, input logic aw,
                      input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic be, input logic [AW-1:0] ba);
      rst         = r;
      bus0.a_en   = ae;  bus1.a_en   = ae;
      bus0.a_we   = aw;  bus1.a_we   = aw;
      bus0.a_addr = aa;  bus1.a_addr = aa;
      bus0.a_din  = ad;  bus1.a_din  = ad;
      bus0.b_en   = be;  bus1.b_en   = be;
      bus0.b_addr = ba;  bus1.b_addr = ba;
      @(posedge clk);
      #1;
      model_edge(r, ae, aw, aa, ad, be, ba);
      compare_all();
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic wr(input logic [AW-1:0] aa, input logic [DW-1:0] ad);
      cyc(1'b0, 1'b1, 1'b1, aa, ad, 1'b0, '0);
   endtask

   // Idle until busy drops; returns edges spent, bounded
   task automatic wait_ready(output int n);
      n = 0;
      do begin
         idle();
         n++;
      end while (bus0.busy && n < 40);
      if (n >= 40) check("ready_timeout", 32'(bus0.busy), 32'd0);
   endtask

   initial begin
      int n;
      int pulses;
      logic          ae, aw, be;
      logic [AW-1:0] aa, ba;
      logic [DW-1:0] ad;

      // Reset, then clear length with a write issued during busy
      cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      check("rst_busy", 32'(bus0.busy), 32'd1);
      check("rst_bdout", 32'(bus0.b_dout), 32'd0);
      n = 0;
      do begin
         if (n == 3) begin
            wr(4'd2, 8'h77);
            check("busy_wr_avalid", 32'(bus0.a_valid), 32'd0);
         end else begin
            idle();
         end
         n++;
      end while (bus0.busy && n < 40);
      check("clear_len", 32'(n), 32'd16);

      cyc(1'b0, 1'b1, 1'b0, 4'd2, '0, 1'b1, 4'd5);
      check("rd5_bvalid", 32'(bus0.b_valid), 32'd1);
      check("rd5_bdout", 32'(bus0.b_dout), 32'h00);
      check("rd2_ignored", 32'(bus0.a_dout), 32'h00);

      // Two writes, then parallel reads
      wr(4'd0, 8'h05);
      wr(4'd1, 8'h15);
      cyc(1'b0, 1'b1, 1'b0, 4'd0, '0, 1'b1, 4'd1);
      check("par_a", 32'(bus0.a_dout), 32'h05);
      check("par_b", 32'(bus0.b_dout), 32'h15);
      idle();
      check("par_avalid_off", 32'(bus0.a_valid), 32'd0);

      // Read-during-write collision on address 3
      wr(4'd3, 8'hAA);
      cyc(1'b0, 1'b1, 1'b1, 4'd3, 8'h55, 1'b1, 4'd3);
      check("rdw_old", 32'(bus0.b_dout), 32'hAA);
      check("rdw_new", 32'(bus1.b_dout), 32'h55);
      cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd3);
      check("rdw_after0", 32'(bus0.b_dout), 32'h55);
      check("rdw_after1", 32'(bus1.b_dout), 32'h55);

      // Address extremes and back-to-back streaming
      wr(4'd15, 8'hF0);
      wr(4'd0, 8'h0F);
      cyc(1'b0, 1'b1, 1'b0, 4'd15, '0, 1'b1, 4'd0);
      check("top_addr", 32'(bus0.a_dout), 32'hF0);
      check("bot_addr", 32'(bus0.b_dout), 32'h0F);
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 1'b0, AW'(15 - i), '0, 1'b1, AW'(i));
         if (bus0.b_valid) pulses++;
      end
      check("stream_pulses", 32'(pulses), 32'd16);

      // Reset mid-clear restarts the sequencer in full
      wr(4'd7, 8'h33);
      cyc(1'b0, 1'b1, 1'b0, 4'd7, '0, 1'b1, 4'd7);
      cyc(1'b1, 1'b1, 1'b0, 4'd7, '0, 1'b1, 4'd7);
      check("rst_adout", 32'(bus0.a_dout), 32'd0);
      check("rst_bvalid", 32'(bus0.b_valid), 32'd0);
      for (int i = 0; i < 5; i++) idle();
      cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      wait_ready(n);
      check("reclear_len", 32'(n), 32'd16);
      cyc(1'b0, 1'b1, 1'b0, 4'd7, '0, 1'b0, '0);
      check("rd7_cleared", 32'(bus0.a_dout), 32'h00);

      // Randomized traffic with forced collisions and rare resets
      for (int i = 0; i < 600; i++) begin
         ae = 1'($urandom_range(0, 1));
         aw = 1'($urandom_range(0, 1));
         aa = AW'($urandom_range(0, DEPTH - 1));
         ad = DW'($urandom);
         be = 1'($urandom_range(0, 1));
         ba = ($urandom_range(0, 2) == 0) ? aa : AW'($urandom_range(0, DEPTH - 1));
         cyc(($urandom_range(0, 99) == 0), ae, aw, aa, ad, be, ba);
      end
      wait_ready(n);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
